// File: rtl/bcd_seg_scan.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bcd_seg_scan: buffered 3-digit BCD value multiplexed onto a common-anode  |
// | 7-segment display with leading-zero blanking and per-slot dead time.      |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module bcd_seg_scan #(
  parameter int CLK_DIV  = 50000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] bcd_in,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [6:0] seg_n,
  output logic [2:0] an_n,
  output logic       frame_done
);

  localparam int                c_cnt_w    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(CLK_DIV - 1);
  localparam logic [6:0]        c_seg_off  = 7'h7F;
  localparam logic [2:0]        c_an_off   = 3'b111;

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [c_cnt_w-1:0]   cnt_q, cnt_d;
  logic [9:0]           pend_q, pend_d;
  logic                 pend_full_q, pend_full_d;
  logic [9:0]           disp_q, disp_d;
  logic [6:0]           seg_n_q, seg_n_d;
  logic [2:0]           an_n_q, an_n_d;
  logic                 frame_done_q, frame_done_d;

  logic                 tick;
  logic                 wrap;
  logic [3:0]           d0, d1, d2;
  logic                 blank1, blank2;
  logic [3:0]           cur_dig;
  logic                 cur_blank;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  assign tick = (cnt_q == c_cnt_last);
  assign wrap = tick && (state_q == S2);

  assign d0 = disp_q[3:0];
  assign d1 = disp_q[7:4];
  assign d2 = {2'b00, disp_q[9:8]};

  // Tens digit only blanks when the hundreds digit is blank as well.
  assign blank2 = BLANK_LZ && (d2 == 4'd0);
  assign blank1 = blank2 && (d1 == 4'd0);

  always_comb begin
    cnt_d        = tick ? '0 : cnt_q + 1'b1;
    state_d      = state_q;
    pend_d       = pend_q;
    pend_full_d  = pend_full_q;
    disp_d       = disp_q;
    frame_done_d = wrap;
    cur_dig      = d0;
    cur_blank    = 1'b0;
    an_n_d       = c_an_off;
    seg_n_d      = c_seg_off;

    if (tick) begin
      case (state_q)
        S0:      state_d = S1;
        S1:      state_d = S2;
        default: state_d = S0;
      endcase
    end

    // Swap in the buffered value only between frames so no frame mixes values.
    if (wrap && pend_full_q) begin
      disp_d      = pend_q;
      pend_full_d = 1'b0;
    end
    if (in_valid && !pend_full_q) begin
      pend_d      = bcd_in;
      pend_full_d = 1'b1;
    end

    case (state_q)
      S1: begin
        cur_dig   = d1;
        cur_blank = blank1;
      end
      S2: begin
        cur_dig   = d2;
        cur_blank = blank2;
      end
      default: begin
        cur_dig   = d0;
        cur_blank = 1'b0;
      end
    endcase

    // The slot-change cycle drives everything off to avoid ghosting.
    if (!tick) begin
      case (state_q)
        S1:      an_n_d = 3'b101;
        S2:      an_n_d = 3'b011;
        default: an_n_d = 3'b110;
      endcase
      seg_n_d = cur_blank ? c_seg_off : seg_decode(cur_dig);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S0;
      cnt_q        <= '0;
      pend_q       <= '0;
      pend_full_q  <= 1'b0;
      disp_q       <= '0;
      seg_n_q      <= c_seg_off;
      an_n_q       <= c_an_off;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      pend_full_q  <= pend_full_d;
      disp_q       <= disp_d;
      seg_n_q      <= seg_n_d;
      an_n_q       <= an_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign in_ready   = ~pend_full_q;
  assign seg_n      = seg_n_q;
  assign an_n       = an_n_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire
